uart_pkt_parser: RTL and testbench
==================================

Name: uart_pkt_parser

Overview:
- Byte-stream framer that sits directly downstream of the UART receiver. It consumes one-cycle received-byte strobes and hunts for framed packets of the form SOF, LEN, PAYLOAD[LEN], CSUM.
- It checks length and checksum, buffers the payload internally, then replays a good payload on a valid/ready byte stream with a last marker. Bad frames are discarded and flagged.

Parameters:
- SOF, 8'hA5, start-of-frame byte value.
- MAX_LEN, 16, maximum payload length in bytes; sizes the internal payload buffer (1..255).
- TIMEOUT_CYCLES, 5000, inter-byte idle limit in clk cycles. Used only when UART_PKT_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_data  in  8  received byte; valid only when in_valid=1
- in_valid  in  1  one-cycle strobe per received byte; no backpressure is possible
- out_data  out  8  payload byte
- out_valid  out  1  out_data holds a payload byte
- out_last  out  1  high with the final payload byte of the packet
- out_ready  in  1  downstream accepts a byte
- pkt_len  out  8  LEN of the packet being emitted; held until the next packet is emitted
- err_len  out  1  one-cycle pulse: LEN=0 or LEN>MAX_LEN
- err_csum  out  1  one-cycle pulse: checksum mismatch
- err_drop  out  1  one-cycle pulse: input byte discarded during EMIT
- err_timeout  out  1  one-cycle pulse: inter-byte timeout
- drop_cnt  out  8  saturating count of dropped bytes; cleared only by rst

Behaviour:
- Reset values:
  - All outputs 0; out_data 0; drop_cnt 0.
  - State IDLE; running checksum and byte index 0.
  - A reset mid-packet or mid-emit discards everything and returns to IDLE.
- Checksum: 8-bit sum, modulo 256, of the LEN byte and all payload bytes. A frame is good when the CSUM byte equals this sum.
- States and transitions (all advance only on in_valid, except in EMIT):
  - IDLE: a byte equal to SOF goes to LEN. Any other byte is silently ignored.
  - LEN:
    - 0 or >MAX_LEN: pulse err_len the next cycle and go to IDLE.
    - Otherwise: latch the length, csum=LEN, index=0, go to PAYLOAD.
  - PAYLOAD: store the byte at buffer[index], add it to csum, index+1. After the LEN-th byte, go to CSUM. Bytes equal to SOF inside the payload are plain data.
  - CSUM:
    - Match: pkt_len<=LEN, go to EMIT. out_valid=1 with buffer[0] on the cycle after the CSUM strobe.
    - Mismatch: pulse err_csum the next cycle and go to IDLE. No out_valid is ever raised for the frame.
  - EMIT:
    - A byte transfers on out_valid && out_ready; then the next byte is presented the following cycle (one byte per cycle at full throughput).
    - out_last=1 only with buffer[LEN-1].
    - On transfer of the last byte: out_valid and out_last drop next cycle, state IDLE.
    - out_data, out_valid and out_last are held stable while out_ready=0.
- Input during EMIT: every in_valid byte is discarded, including one arriving in the same cycle as the last transfer.
  - Each discarded byte pulses err_drop the next cycle and increments drop_cnt.
  - drop_cnt saturates at 255.
  - The parser re-enters IDLE after EMIT and does not retroactively use dropped bytes.
- A single-byte payload (LEN=1) emits one byte with out_valid and out_last both set.
- Error pulses are registered: one cycle wide, exactly one cycle after the offending strobe.

Optional Feature:
- Macro: UART_PKT_TIMEOUT_EN.
- Defined:
  - A counter runs in LEN, PAYLOAD and CSUM, and resets to 0 on each in_valid.
  - When it reaches TIMEOUT_CYCLES with no in_valid, err_timeout pulses for one cycle and the state returns to IDLE, discarding the partial frame.
  - The counter is idle (held 0) in IDLE and EMIT.
- Not defined: no counter is built and err_timeout is tied 0. The port is still present. A stalled partial frame waits indefinitely.

Test Plan:
- Good frame: strobes A5 03 11 22 33 69 with out_ready=1 -> out_data 11,22,33 on consecutive cycles starting 1 cycle after the 69 strobe; out_last only on 33; pkt_len=3; no error pulses.
- Bad checksum: A5 03 11 22 33 68 -> err_csum pulse 1 cycle after 68; out_valid never asserts; the following good frame A5 01 7E 7F is emitted as single byte 7E with out_last=1.
- Length errors: A5 00 and, with MAX_LEN=16, A5 11 -> err_len pulse after each LEN byte; the parser returns to IDLE and the next bytes are ignored until A5.
- Hunting plus SOF in payload: 00 FF 5A A5 02 A5 10 B7 -> garbage ignored; emits A5,10 with last on 10.
- Backpressure and drop: good 3-byte frame with out_ready=0 for 10 cycles while 2 in_valid bytes arrive -> out_data held at 11; err_drop pulses twice; drop_cnt=2; after out_ready=1, 11,22,33 are emitted intact.
- Timeout (macro defined, TIMEOUT_CYCLES=100): A5 02 11 then no strobes -> err_timeout pulse exactly 100 cycles after the 11 strobe; a following A5 01 44 45 emits 44. Macro undefined: no err_timeout pulse, and the late bytes 22 35 complete the frame, which is emitted as 11,22.

Source files
------------

// File: rtl/uart_pkt_parser.sv
// UART byte-stream framer: SOF, LEN, PAYLOAD[LEN], CSUM -> valid/ready stream.
// Optional inter-byte timeout when UART_PKT_TIMEOUT_EN is defined.
module uart_pkt_parser #(
    parameter logic [7:0] SOF            = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic [7:0] pkt_len,
    output logic       err_len,
    output logic       err_csum,
    output logic       err_drop,
    output logic       err_timeout,
    output logic [7:0] drop_cnt
);
    localparam int         IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAXL = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_PAY, S_CSUM, S_EMIT
    } state_t;

    state_t        r_state;
    logic [7:0]    r_buf [2**IW];
    logic [7:0]    r_len;
    logic [7:0]    r_csum;
    logic [7:0]    r_idx;
    logic [IW-1:0] w_nidx;

    assign w_nidx = r_idx[IW-1:0] + IW'(1);

`ifdef UART_PKT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_tcnt;
    logic          w_inframe;
    logic          w_tmo;

    assign w_inframe = (r_state == S_LEN) || (r_state == S_PAY) ||
                       (r_state == S_CSUM);
    assign w_tmo = w_inframe && !in_valid &&
                   (r_tcnt == CW'(TIMEOUT_CYCLES - 1));
`else
    // No counter: output is a constant zero.
    assign err_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_csum    <= '0;
            r_idx     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            pkt_len   <= '0;
            err_len   <= 1'b0;
            err_csum  <= 1'b0;
            err_drop  <= 1'b0;
            drop_cnt  <= '0;
`ifdef UART_PKT_TIMEOUT_EN
            err_timeout <= 1'b0;
            r_tcnt      <= '0;
`endif
        end else begin
            err_len  <= 1'b0;
            err_csum <= 1'b0;
            err_drop <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid && in_data == SOF)
                        r_state <= S_LEN;
                end
                S_LEN: begin
                    if (in_valid) begin
                        if (in_data == 8'd0 || in_data > MAXL) begin
                            err_len <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_len   <= in_data;
                            r_csum  <= in_data;
                            r_idx   <= '0;
                            r_state <= S_PAY;
                        end
                    end
                end
                S_PAY: begin
                    if (in_valid) begin
                        r_buf[r_idx[IW-1:0]] <= in_data;
                        r_csum <= r_csum + in_data;
                        r_idx  <= r_idx + 8'd1;
                        if (r_idx + 8'd1 == r_len)
                            r_state <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (in_valid) begin
                        if (in_data == r_csum) begin
                            pkt_len   <= r_len;
                            r_idx     <= '0;
                            out_data  <= r_buf['0];
                            out_valid <= 1'b1;
                            out_last  <= (r_len == 8'd1);
                            r_state   <= S_EMIT;
                        end else begin
                            err_csum <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                S_EMIT: begin
                    // No backpressure upstream: input bytes here are lost.
                    if (in_valid) begin
                        err_drop <= 1'b1;
                        if (drop_cnt != 8'hFF)
                            drop_cnt <= drop_cnt + 8'd1;
                    end
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_idx    <= r_idx + 8'd1;
                            out_data <= r_buf[w_nidx];
                            out_last <= (r_idx + 8'd2 == r_len);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef UART_PKT_TIMEOUT_EN
            err_timeout <= w_tmo;
            if (w_tmo)
                r_state <= S_IDLE;
            if (w_inframe && !in_valid && !w_tmo)
                r_tcnt <= r_tcnt + CW'(1);
            else
                r_tcnt <= '0;
`endif
        end
    end
endmodule

// File: tb/tb_uart_pkt_parser.sv
// Scoreboard bench for uart_pkt_parser: queued expected bytes, monitor
// pops on each handshake; error pulses counted and compared per test.
module tb_uart_pkt_parser;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic [7:0] pkt_len;
    logic       err_len;
    logic       err_csum;
    logic       err_drop;
    logic       err_timeout;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    int n_len = 0, n_csum = 0, n_drop = 0, n_tmo = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    uart_pkt_parser dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready),
        .pkt_len(pkt_len),
        .err_len(err_len), .err_csum(err_csum),
        .err_drop(err_drop), .err_timeout(err_timeout),
        .drop_cnt(drop_cnt)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, inputs change after rising.
    always @(negedge clk) begin
        if (!rst) begin
            if (err_len) n_len++;
            if (err_csum) n_csum++;
            if (err_drop) n_drop++;
            if (err_timeout) n_tmo++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h/%0b expected none",
                             out_data, out_last);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("out_byte", {out_last, out_data}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic strobe(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk({nm, "_drained"}, exp_q.size(), 0);
        chk({nm, "_valid_low"}, out_valid, 0);
    endtask

    task automatic chk_errs(input string nm, input int l, input int c,
                            input int d);
        chk({nm, "_err_len"}, n_len, l);
        chk({nm, "_err_csum"}, n_csum, c);
        chk({nm, "_err_drop"}, n_drop, d);
        chk({nm, "_err_tmo"}, n_tmo, 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_pkt_len", pkt_len, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_errs", {err_len, err_csum, err_drop, err_timeout}, 0);
        rst = 1'b0;
        tick();

        // Good frame, full throughput, exact latency.
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 1);
        strobe(8'hA5); strobe(8'h03); strobe(8'h11);
        strobe(8'h22); strobe(8'h33); strobe(8'h69);
        chk("t1_c0", {out_valid, out_last, out_data}, {2'b10, 8'h11});
        tick();
        chk("t1_c1", {out_valid, out_last, out_data}, {2'b10, 8'h22});
        tick();
        chk("t1_c2", {out_valid, out_last, out_data}, {2'b11, 8'h33});
        drain("t1");
        chk("t1_pkt_len", pkt_len, 3);
        chk_errs("t1", 0, 0, 0);

        // Bad checksum then single-byte frame.
        strobe(8'hA5); strobe(8'h03); strobe(8'h11);
        strobe(8'h22); strobe(8'h33); strobe(8'h68);
        chk("t2_csum_pulse", {err_csum, out_valid}, 2'b10);
        tick();
        chk("t2_csum_width", {err_csum, out_valid}, 2'b00);
        chk("t2_pkt_len_held", pkt_len, 3);
        push(8'h7E, 1);
        strobe(8'hA5); strobe(8'h01); strobe(8'h7E); strobe(8'h7F);
        chk("t2_single", {out_valid, out_last, out_data}, {2'b11, 8'h7E});
        drain("t2");
        chk("t2_pkt_len", pkt_len, 1);
        chk_errs("t2", 0, 1, 0);

        // Length errors, then garbage ignored until SOF.
        strobe(8'hA5); strobe(8'h00);
        chk("t3_len0_pulse", err_len, 1);
        strobe(8'h55); strobe(8'hA5); strobe(8'h11);
        chk("t3_len17_pulse", err_len, 1);
        strobe(8'h22); strobe(8'h33);
        push(8'h05, 1);
        strobe(8'hA5); strobe(8'h01); strobe(8'h05); strobe(8'h06);
        drain("t3");
        chk_errs("t3", 2, 1, 0);

        // Hunting plus SOF inside the payload.
        push(8'hA5, 0); push(8'h10, 1);
        strobe(8'h00); strobe(8'hFF); strobe(8'h5A); strobe(8'hA5);
        strobe(8'h02); strobe(8'hA5); strobe(8'h10); strobe(8'hB7);
        drain("t4");
        chk("t4_pkt_len", pkt_len, 2);

        // Maximum length frame: 1..16, csum = 16 + 136 = 0x98.
        strobe(8'hA5); strobe(8'h10);
        for (int i = 1; i <= 16; i++) begin
            push(8'(i), i == 16);
            strobe(8'(i));
        end
        strobe(8'h98);
        drain("t5");
        chk("t5_pkt_len", pkt_len, 16);
        chk_errs("t5", 2, 1, 0);

        // Backpressure with dropped input bytes.
        out_ready = 1'b0;
        strobe(8'hA5); strobe(8'h03); strobe(8'h11);
        strobe(8'h22); strobe(8'h33); strobe(8'h69);
        for (int c = 0; c < 10; c++) begin
            chk("t6_hold", {out_valid, out_last, out_data}, {2'b10, 8'h11});
            if (c == 2 || c == 5) begin
                strobe(8'hA5);
                chk("t6_drop_pulse", err_drop, 1);
            end else begin
                tick();
            end
        end
        chk("t6_drop_cnt", drop_cnt, 2);
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 1);
        out_ready = 1'b1;
        drain("t6");
        chk_errs("t6", 2, 1, 2);

        // Byte arriving in the same cycle as the last transfer is dropped.
        push(8'h09, 1);
        strobe(8'hA5); strobe(8'h01); strobe(8'h09); strobe(8'h0A);
        strobe(8'hA5);
        chk("t7_drop_last", {err_drop, out_valid}, 2'b10);
        chk("t7_drop_cnt", drop_cnt, 3);
        strobe(8'h01); strobe(8'h44); strobe(8'h45);
        drain("t7");
        chk_errs("t7", 2, 1, 3);

        // Stalled partial frame waits (no timeout at default settings).
        strobe(8'hA5); strobe(8'h02); strobe(8'h11);
        repeat (150) tick();
        chk("t8_no_tmo", n_tmo, 0);
        push(8'h11, 0); push(8'h22, 1);
        strobe(8'h22); strobe(8'h35);
        drain("t8");
        chk("t8_pkt_len", pkt_len, 2);

        // Reset mid-emit discards the packet.
        out_ready = 1'b0;
        strobe(8'hA5); strobe(8'h01); strobe(8'h77); strobe(8'h78);
        chk("t9_pre_rst", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t9_rst_valid", {out_valid, out_last}, 0);
        chk("t9_rst_drop_cnt", drop_cnt, 0);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("t9_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
